// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - NUM_CH-master memory arbiter; MEM_ARB_RR_EN selects round-robin, otherwise fixed priority
module mem_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 1
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [NUM_CH-1:0]        HTRANS,
  input  logic [NUM_CH*ADDR_W-1:0] HADDR,
  input  logic [NUM_CH-1:0]        HWRITE,
  input  logic [NUM_CH*DATA_W-1:0] HWDATA,
  input  logic                     PREADY,
  output logic                     PVALID,
  output logic [ADDR_W-1:0]        PADDR,
  output logic                     PWRITE,
  output logic [DATA_W-1:0]        PDATA,
  output logic [ID_W-1:0]          GRANT_ID,
  output logic [NUM_CH-1:0]        stall
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state;
  logic                any_req;
  logic                complete;
  logic [ID_W-1:0]     win_id;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_write;

  // Request summary and completion of the access currently on the memory side
  always_comb begin
    any_req  = |HTRANS;
    complete = (state == ACCESS) && PREADY;
  end

`ifdef MEM_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] next_ptr;
  logic [ID_W-1:0] base;
  int              idx;

  // Pointer value after the current grant completes: (GRANT_ID+1) mod NUM_CH
  always_comb begin
    next_ptr = (int'(GRANT_ID) == NUM_CH - 1) ? '0 : GRANT_ID + ID_W'(1);
  end

  // Round-robin pick: back-to-back reloads use the pointer that the completing grant produces
  always_comb begin
    base   = (state == ACCESS) ? next_ptr : rr_ptr;
    win_id = '0;
    idx    = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(base) + k) % NUM_CH;
      if (HTRANS[idx]) win_id = ID_W'(idx);
    end
  end
`else
  // Fixed priority pick: lowest requesting index wins
  always_comb begin
    win_id = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (HTRANS[k]) win_id = ID_W'(k);
    end
  end
`endif

  // Steer the winner's address, data and direction toward the output registers
  always_comb begin
    sel_addr  = '0;
    sel_data  = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win_id == ID_W'(i)) begin
        sel_addr  = HADDR[i*ADDR_W +: ADDR_W];
        sel_data  = HWDATA[i*DATA_W +: DATA_W];
        sel_write = HWRITE[i];
      end
    end
  end

  // Requesters stay stalled until the cycle in which their own access completes
  always_comb begin
    stall = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      stall[i] = HTRANS[i] & HRESET & ~(complete & (GRANT_ID == ID_W'(i)));
    end
  end

  // Arbiter FSM: IDLE loads the first winner; ACCESS holds until PREADY, then reloads or idles
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state    <= IDLE;
      PVALID   <= 1'b0;
      PADDR    <= '0;
      PWRITE   <= 1'b0;
      PDATA    <= '0;
      GRANT_ID <= '0;
`ifdef MEM_ARB_RR_EN
      rr_ptr   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            PADDR    <= sel_addr;
            PWRITE   <= sel_write;
            PDATA    <= sel_data;
            GRANT_ID <= win_id;
            PVALID   <= 1'b1;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (PREADY) begin
`ifdef MEM_ARB_RR_EN
            rr_ptr <= next_ptr;
`endif
            if (any_req) begin
              PADDR    <= sel_addr;
              PWRITE   <= sel_write;
              PDATA    <= sel_data;
              GRANT_ID <= win_id;
              PVALID   <= 1'b1;
            end else begin
              PVALID <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: begin
          PVALID <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (2- and 4-channel instances)
module tb_mem_arbiter;

  logic         clk;
  logic         hreset;

  logic [1:0]   htrans;
  logic [127:0] haddr;
  logic [1:0]   hwrite;
  logic [127:0] hwdata;
  logic         pready;
  logic         pvalid;
  logic [63:0]  paddr;
  logic         pwrite;
  logic [63:0]  pdata;
  logic [0:0]   grant_id;
  logic [1:0]   stall;

  logic [3:0]   htrans4;
  logic [63:0]  haddr4;
  logic [3:0]   hwrite4;
  logic [63:0]  hwdata4;
  logic         pready4;
  logic         pvalid4;
  logic [15:0]  paddr4;
  logic         pwrite4;
  logic [15:0]  pdata4;
  logic [1:0]   grant_id4;
  logic [3:0]   stall4;

  int n_checks;
  int n_fail;
  bit rr;

  mem_arbiter #(.NUM_CH(2), .ADDR_W(64), .DATA_W(64), .ID_W(1)) dut (
    .HCLK(clk), .HRESET(hreset), .HTRANS(htrans), .HADDR(haddr), .HWRITE(hwrite),
    .HWDATA(hwdata), .PREADY(pready), .PVALID(pvalid), .PADDR(paddr), .PWRITE(pwrite),
    .PDATA(pdata), .GRANT_ID(grant_id), .stall(stall)
  );

  mem_arbiter #(.NUM_CH(4), .ADDR_W(16), .DATA_W(16), .ID_W(2)) dut4 (
    .HCLK(clk), .HRESET(hreset), .HTRANS(htrans4), .HADDR(haddr4), .HWRITE(hwrite4),
    .HWDATA(hwdata4), .PREADY(pready4), .PVALID(pvalid4), .PADDR(paddr4), .PWRITE(pwrite4),
    .PDATA(pdata4), .GRANT_ID(grant_id4), .stall(stall4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    htrans = 2'b11;
    #1;
    n_checks++; if (pvalid !== 1'b0) begin n_fail++; $display("FAIL reset_pvalid: got %0h expected 0", pvalid); end
    n_checks++; if (paddr !== 64'h0) begin n_fail++; $display("FAIL reset_paddr: got %0h expected 0", paddr); end
    n_checks++; if (pdata !== 64'h0) begin n_fail++; $display("FAIL reset_pdata: got %0h expected 0", pdata); end
    n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %0h expected 0", grant_id); end
    n_checks++; if (stall !== 2'b00) begin n_fail++; $display("FAIL reset_stall: got %0h expected 0", stall); end
    tick();
    n_checks++; if (pvalid !== 1'b0) begin n_fail++; $display("FAIL reset_hold_pvalid: got %0h expected 0", pvalid); end
    htrans = 2'b00;
    hreset = 1'b1;
    tick();
    n_checks++; if (pvalid !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle: got %0h expected 0", pvalid); end
  endtask

  task automatic test_single();
    htrans = 2'b01;
    haddr[63:0] = 64'h100;
    hwrite = 2'b01;
    hwdata[63:0] = 64'hAA;
    pready = 1'b0;
    #1;
    n_checks++; if (stall !== 2'b01) begin n_fail++; $display("FAIL single_stall_idle: got %0h expected 1", stall); end
    tick();
    n_checks++; if (pvalid !== 1'b1) begin n_fail++; $display("FAIL single_pvalid: got %0h expected 1", pvalid); end
    n_checks++; if (paddr !== 64'h100) begin n_fail++; $display("FAIL single_paddr: got %0h expected 100", paddr); end
    n_checks++; if (pdata !== 64'hAA) begin n_fail++; $display("FAIL single_pdata: got %0h expected aa", pdata); end
    n_checks++; if (pwrite !== 1'b1) begin n_fail++; $display("FAIL single_pwrite: got %0h expected 1", pwrite); end
    n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL single_grant: got %0h expected 0", grant_id); end
    n_checks++; if (stall !== 2'b01) begin n_fail++; $display("FAIL single_stall_c1: got %0h expected 1", stall); end
    tick();
    n_checks++; if (stall !== 2'b01) begin n_fail++; $display("FAIL single_stall_c2: got %0h expected 1", stall); end
    n_checks++; if (paddr !== 64'h100) begin n_fail++; $display("FAIL single_paddr_hold: got %0h expected 100", paddr); end
    pready = 1'b1;
    #1;
    n_checks++; if (stall !== 2'b00) begin n_fail++; $display("FAIL single_stall_done: got %0h expected 0", stall); end
    htrans = 2'b00;
    tick();
    pready = 1'b0;
    n_checks++; if (pvalid !== 1'b0) begin n_fail++; $display("FAIL single_back_idle: got %0h expected 0", pvalid); end
  endtask

  task automatic test_idle_pready();
    pready = 1'b1;
    tick();
    n_checks++; if (pvalid !== 1'b0) begin n_fail++; $display("FAIL idle_pready_ignored: got %0h expected 0", pvalid); end
    htrans = 2'b10;
    haddr[127:64] = 64'h180;
    hwrite = 2'b00;
    tick();
    n_checks++; if (pvalid !== 1'b1) begin n_fail++; $display("FAIL idle_pready_grant: got %0h expected 1", pvalid); end
    n_checks++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL idle_pready_id: got %0h expected 1", grant_id); end
    n_checks++; if (pwrite !== 1'b0) begin n_fail++; $display("FAIL idle_pready_read: got %0h expected 0", pwrite); end
    n_checks++; if (stall !== 2'b00) begin n_fail++; $display("FAIL idle_pready_stall: got %0h expected 0", stall); end
    htrans = 2'b00;
    tick();
    pready = 1'b0;
    n_checks++; if (pvalid !== 1'b0) begin n_fail++; $display("FAIL idle_pready_end: got %0h expected 0", pvalid); end
  endtask

  task automatic test_back_to_back();
    logic [0:0]  exp_g;
    logic [1:0]  exp_s;
    logic [63:0] exp_a;
    haddr[63:0]   = 64'h1000;
    haddr[127:64] = 64'h2000;
    htrans = 2'b11;
    pready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_g = rr ? 1'(i % 2) : 1'b0;
      exp_s = 2'b11 & ~(2'b01 << exp_g);
      exp_a = (exp_g == 1'b1) ? 64'h2000 : 64'h1000;
      n_checks++; if (pvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_pvalid[%0d]: got %0h expected 1", i, pvalid); end
      n_checks++; if (grant_id !== exp_g) begin n_fail++; $display("FAIL b2b_grant[%0d]: got %0h expected %0h", i, grant_id, exp_g); end
      n_checks++; if (paddr !== exp_a) begin n_fail++; $display("FAIL b2b_paddr[%0d]: got %0h expected %0h", i, paddr, exp_a); end
      n_checks++; if (stall !== exp_s) begin n_fail++; $display("FAIL b2b_stall[%0d]: got %0h expected %0h", i, stall, exp_s); end
    end
    htrans = 2'b00;
    tick();
    pready = 1'b0;
    n_checks++; if (pvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %0h expected 0", pvalid); end
  endtask

  task automatic test_reset_mid_access();
    htrans = 2'b10;
    haddr[127:64] = 64'h300;
    tick();
    n_checks++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_grant: got %0h expected 1", grant_id); end
    #2;
    hreset = 1'b0;
    #1;
    n_checks++; if (pvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pvalid: got %0h expected 0", pvalid); end
    n_checks++; if (paddr !== 64'h0) begin n_fail++; $display("FAIL rst_mid_paddr: got %0h expected 0", paddr); end
    n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL rst_mid_grant: got %0h expected 0", grant_id); end
    n_checks++; if (stall !== 2'b00) begin n_fail++; $display("FAIL rst_mid_stall: got %0h expected 0", stall); end
    #2;
    hreset = 1'b1;
    tick();
    n_checks++; if (pvalid !== 1'b1) begin n_fail++; $display("FAIL rst_after_pvalid: got %0h expected 1", pvalid); end
    n_checks++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL rst_after_grant: got %0h expected 1", grant_id); end
    n_checks++; if (paddr !== 64'h300) begin n_fail++; $display("FAIL rst_after_paddr: got %0h expected 300", paddr); end
    pready = 1'b1;
    htrans = 2'b00;
    tick();
    pready = 1'b0;
    n_checks++; if (pvalid !== 1'b0) begin n_fail++; $display("FAIL rst_after_end: got %0h expected 0", pvalid); end
  endtask

  task automatic test_four_channel();
    haddr4 = {16'h0033, 16'h0022, 16'h0011, 16'h0000};
    hwdata4 = {16'hD3, 16'hD2, 16'hD1, 16'hD0};
    hwrite4 = 4'b1000;
    htrans4 = 4'b1000;
    tick();
    n_checks++; if (grant_id4 !== 2'd3) begin n_fail++; $display("FAIL four_first_grant: got %0h expected 3", grant_id4); end
    pready4 = 1'b1;
    #1;
    n_checks++; if (stall4 !== 4'b0000) begin n_fail++; $display("FAIL four_first_stall: got %0h expected 0", stall4); end
    htrans4 = 4'b0000;
    tick();
    pready4 = 1'b0;
    n_checks++; if (pvalid4 !== 1'b0) begin n_fail++; $display("FAIL four_first_idle: got %0h expected 0", pvalid4); end
    htrans4 = 4'b1010;
    tick();
    n_checks++; if (grant_id4 !== 2'd1) begin n_fail++; $display("FAIL four_win1_grant: got %0h expected 1", grant_id4); end
    n_checks++; if (paddr4 !== 16'h0011) begin n_fail++; $display("FAIL four_win1_paddr: got %0h expected 11", paddr4); end
    n_checks++; if (pdata4 !== 16'hD1) begin n_fail++; $display("FAIL four_win1_pdata: got %0h expected d1", pdata4); end
    n_checks++; if (stall4 !== 4'b1010) begin n_fail++; $display("FAIL four_win1_stall: got %0h expected a", stall4); end
    htrans4 = 4'b1000;
    tick();
    n_checks++; if (pvalid4 !== 1'b1) begin n_fail++; $display("FAIL four_drop_pvalid: got %0h expected 1", pvalid4); end
    n_checks++; if (grant_id4 !== 2'd1) begin n_fail++; $display("FAIL four_drop_grant: got %0h expected 1", grant_id4); end
    n_checks++; if (paddr4 !== 16'h0011) begin n_fail++; $display("FAIL four_drop_paddr: got %0h expected 11", paddr4); end
    pready4 = 1'b1;
    #1;
    n_checks++; if (stall4 !== 4'b1000) begin n_fail++; $display("FAIL four_drop_stall: got %0h expected 8", stall4); end
    tick();
    n_checks++; if (pvalid4 !== 1'b1) begin n_fail++; $display("FAIL four_win3_pvalid: got %0h expected 1", pvalid4); end
    n_checks++; if (grant_id4 !== 2'd3) begin n_fail++; $display("FAIL four_win3_grant: got %0h expected 3", grant_id4); end
    n_checks++; if (paddr4 !== 16'h0033) begin n_fail++; $display("FAIL four_win3_paddr: got %0h expected 33", paddr4); end
    n_checks++; if (pwrite4 !== 1'b1) begin n_fail++; $display("FAIL four_win3_pwrite: got %0h expected 1", pwrite4); end
    n_checks++; if (stall4 !== 4'b0000) begin n_fail++; $display("FAIL four_win3_stall: got %0h expected 0", stall4); end
    htrans4 = 4'b0000;
    tick();
    pready4 = 1'b0;
    n_checks++; if (pvalid4 !== 1'b0) begin n_fail++; $display("FAIL four_end_idle: got %0h expected 0", pvalid4); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
`ifdef MEM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    clk     = 1'b0;
    hreset  = 1'b0;
    htrans  = '0;
    haddr   = '0;
    hwrite  = '0;
    hwdata  = '0;
    pready  = 1'b0;
    htrans4 = '0;
    haddr4  = '0;
    hwrite4 = '0;
    hwdata4 = '0;
    pready4 = 1'b0;
    test_reset();
    test_single();
    test_idle_pready();
    test_back_to_back();
    test_reset_mid_access();
    test_four_channel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
